// File: rtl/shuttle_pkg.sv
// Shared types and constants for the shuttle controller: FSM states,
// bridge drive encodings and a counter-width helper.
package shuttle_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN_R = 3'd1,
        RUN_L = 3'd2,
        BRAKE = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [1:0] MA_OFF = 2'b00;
    localparam logic [1:0] MA_R   = 2'b10;
    localparam logic [1:0] MA_L   = 2'b01;

    // Width of a counter that runs 0 .. n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shuttle_ctrl_sw_debounce.sv
// Two-flop synchroniser plus debouncer: the level flips only after the
// synchronised input has disagreed with it for DEBOUNCE_CYC straight cycles.
module sw_debounce
    import shuttle_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter bit INIT         = 1'b0
) (
    input  logic sclk,
    input  logic s_rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_w(DEBOUNCE_CYC);
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            sync  <= {2{INIT}};
            cnt   <= '0;
            level <= INIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == TC) begin
                cnt   <= '0;
                level <= sync[1];
                rise  <= sync[1];
                fall  <= ~sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/shuttle_ctrl.sv
// Single-axis shuttle controller: debounced inputs, ramped PWM H-bridge drive,
// dead-time braking between legs, run timeout and fault latch.
//
// state | meaning
// IDLE  | bridge off, waiting for a key press
// RUN_R | driving right, duty ramping up
// RUN_L | driving left, duty ramping up
// BRAKE | both legs off for DEAD_CYC cycles, then go to tgt
// FAULT | latched; key press with both limits clear returns to IDLE
module shuttle_ctrl
    import shuttle_pkg::*;
#(
    parameter int PWM_W        = 8,
    parameter int DUTY_MAX     = 200,
    parameter int RAMP_STEP    = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int DEAD_CYC     = 50_000,
    parameter int TIMEOUT_CYC  = 500_000_000
) (
    input  logic             sclk,
    input  logic             s_rst,
    input  logic             key,
    input  logic             catcher,
    input  logic             jockey_r,
    input  logic             jockey_l,
    input  logic             mode,
    output logic [1:0]       MA,
    output logic             busy,
    output logic             fault,
    output logic [PWM_W-1:0] duty
);

    localparam int LW = cnt_w(TIMEOUT_CYC);
    localparam int BW = cnt_w(DEAD_CYC);
    localparam logic [LW-1:0]  LEG_TC = LW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0]  BRK_TC = BW'(DEAD_CYC - 1);
    localparam logic [PWM_W:0] DMAX   = (PWM_W + 1)'(DUTY_MAX);
    localparam logic [PWM_W:0] STEP   = (PWM_W + 1)'(RAMP_STEP);

    logic key_lvl, key_rise, press;
    logic cat_lvl, catch, cat_fall;
    logic lim_r, limr_rise, limr_fall;
    logic lim_l, liml_rise, liml_fall;

    sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .INIT(1'b1)) u_key (
        .sclk(sclk), .s_rst(s_rst), .raw(key),
        .level(key_lvl), .rise(key_rise), .fall(press));
    sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .INIT(1'b0)) u_catcher (
        .sclk(sclk), .s_rst(s_rst), .raw(catcher),
        .level(cat_lvl), .rise(catch), .fall(cat_fall));
    sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .INIT(1'b0)) u_lim_r (
        .sclk(sclk), .s_rst(s_rst), .raw(jockey_r),
        .level(lim_r), .rise(limr_rise), .fall(limr_fall));
    sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .INIT(1'b0)) u_lim_l (
        .sclk(sclk), .s_rst(s_rst), .raw(jockey_l),
        .level(lim_l), .rise(liml_rise), .fall(liml_fall));

    logic unused_edges;
    assign unused_edges = ^{key_lvl, key_rise, cat_lvl, cat_fall,
                            limr_rise, limr_fall, liml_rise, liml_fall};

    state_t           state, state_n, tgt, tgt_n;
    logic             mode_q, mode_n;
    logic [PWM_W-1:0] pwm_cnt;
    logic [LW-1:0]    leg_cnt;
    logic [BW-1:0]    brk_cnt;
    logic [PWM_W:0]   duty_sum;
    logic [PWM_W-1:0] duty_ramp;
    logic [1:0]       ma_n;
    logic             is_run, both_lim;

    assign is_run   = (state == RUN_R) || (state == RUN_L);
    assign both_lim = lim_r && lim_l;
    assign duty_sum = {1'b0, duty} + STEP;
    assign duty_ramp = (duty_sum > DMAX) ? DMAX[PWM_W-1:0] : duty_sum[PWM_W-1:0];

    always_comb begin
        state_n = state;
        tgt_n   = tgt;
        mode_n  = mode_q;
        unique case (state)
            IDLE: begin
                if (press) begin
                    mode_n = mode;
                    if (both_lim)   state_n = FAULT;
                    else if (lim_r) state_n = RUN_L;
                    else            state_n = RUN_R;
                end
            end
            RUN_R, RUN_L: begin
                if (both_lim) begin
                    state_n = FAULT;
                end else if (press || catch) begin
                    state_n = BRAKE;
                    tgt_n   = IDLE;
                end else if ((state == RUN_R && lim_r) || (state == RUN_L && lim_l)) begin
                    state_n = BRAKE;
                    if (!mode_q)              tgt_n = IDLE;
                    else if (state == RUN_R)  tgt_n = RUN_L;
                    else                      tgt_n = RUN_R;
                end else if (leg_cnt == LEG_TC) begin
                    state_n = FAULT;
                end
            end
            BRAKE: begin
                if (both_lim) begin
                    state_n = FAULT;
                end else begin
                    if (press) tgt_n = IDLE;
                    if (brk_cnt == BRK_TC) state_n = press ? IDLE : tgt;
                end
            end
            FAULT: begin
                if (press && !lim_r && !lim_l) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ma_n = MA_OFF;
        if (state == RUN_R && pwm_cnt < duty) ma_n = MA_R;
        if (state == RUN_L && pwm_cnt < duty) ma_n = MA_L;
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state   <= IDLE;
            tgt     <= IDLE;
            mode_q  <= 1'b0;
            pwm_cnt <= '0;
            duty    <= '0;
            leg_cnt <= '0;
            brk_cnt <= '0;
            MA      <= MA_OFF;
        end else begin
            state   <= state_n;
            tgt     <= tgt_n;
            mode_q  <= mode_n;
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            MA      <= ma_n;
            // Leaving or changing legs zeroes duty so every RUN entry starts at 0.
            if (is_run && state_n == state) begin
                leg_cnt <= leg_cnt + LW'(1);
                if (pwm_cnt == '1) duty <= duty_ramp;
            end else begin
                leg_cnt <= '0;
                duty    <= '0;
            end
            if (state == BRAKE && state_n == BRAKE) brk_cnt <= brk_cnt + BW'(1);
            else                                    brk_cnt <= '0;
        end
    end

    assign busy  = is_run || (state == BRAKE);
    assign fault = (state == FAULT);

endmodule

// File: tb/tb_shuttle_ctrl.sv
// Directed bench for shuttle_ctrl with small parameters; each task drives one
// scenario and compares outputs against hand-derived values.
module tb_shuttle_ctrl;
    import shuttle_pkg::*;

    logic       sclk, s_rst, key, catcher, jockey_r, jockey_l, mode;
    logic [1:0] ma;
    logic       busy, fault;
    logic [3:0] duty;

    int vectors = 0;
    int miscompares = 0;

    shuttle_ctrl #(
        .PWM_W(4), .DUTY_MAX(12), .RAMP_STEP(4),
        .DEBOUNCE_CYC(4), .DEAD_CYC(3), .TIMEOUT_CYC(1000)
    ) dut (
        .sclk(sclk), .s_rst(s_rst), .key(key), .catcher(catcher),
        .jockey_r(jockey_r), .jockey_l(jockey_l), .mode(mode),
        .MA(ma), .busy(busy), .fault(fault), .duty(duty)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic wait_for(input state_t s, input int budget);
        for (int i = 0; i < budget && dut.state !== s; i++) @(negedge sclk);
    endtask

    task automatic press_key();
        key = 1'b0;
        repeat (10) @(negedge sclk);
        key = 1'b1;
        repeat (8) @(negedge sclk);
    endtask

    task automatic test_reset();
        vectors++; if (ma !== 2'b00) begin miscompares++; $display("FAIL reset_ma got %b want 00", ma); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b want 0", fault); end
        vectors++; if (duty !== 4'd0) begin miscompares++; $display("FAIL reset_duty got %0d want 0", duty); end
        vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
    endtask

    task automatic test_ramp();
        logic [3:0] prev;
        int steps, ones_r, ones_l;
        bit bad_step, bad_hold;
        mode = 1'b1;
        key = 1'b0;
        wait_for(RUN_R, 20);
        vectors++; if (dut.state !== RUN_R) begin miscompares++; $display("FAIL ramp_enter got %0d want RUN_R", dut.state); end
        vectors++; if (duty !== 4'd0) begin miscompares++; $display("FAIL ramp_entry_duty got %0d want 0", duty); end
        prev = duty; steps = 0; bad_step = 1'b0;
        for (int i = 0; i < 80 && duty !== 4'd12; i++) begin
            @(negedge sclk);
            if (i == 4) key = 1'b1;
            if (duty !== prev) begin
                if (32'(duty) != 32'(prev) + 4) bad_step = 1'b1;
                steps++;
                prev = duty;
            end
        end
        key = 1'b1;
        vectors++; if (duty !== 4'd12) begin miscompares++; $display("FAIL ramp_top got %0d want 12", duty); end
        vectors++; if (steps != 3 || bad_step) begin miscompares++; $display("FAIL ramp_steps got %0d steps bad=%0b want 3 steps of 4", steps, bad_step); end
        bad_hold = 1'b0;
        repeat (20) begin @(negedge sclk); if (duty !== 4'd12) bad_hold = 1'b1; end
        vectors++; if (bad_hold) begin miscompares++; $display("FAIL ramp_hold got duty %0d want 12", duty); end
        ones_r = 0; ones_l = 0;
        repeat (16) begin
            @(negedge sclk);
            if (ma[1] === 1'b1) ones_r++;
            if (ma[0] !== 1'b0) ones_l++;
        end
        vectors++; if (ones_r != 12) begin miscompares++; $display("FAIL pwm_r_high got %0d want 12 of 16", ones_r); end
        vectors++; if (ones_l != 0) begin miscompares++; $display("FAIL pwm_l_idle got %0d want 0", ones_l); end
    endtask

    task automatic test_reverse();
        int n, blen;
        bit bad_ma, bad_brk, seen_l;
        jockey_r = 1'b1;
        bad_ma = 1'b0; bad_brk = 1'b0;
        for (n = 0; n < 40 && dut.state !== BRAKE; n++) begin
            @(negedge sclk);
            if (ma === 2'b11) bad_ma = 1'b1;
        end
        vectors++; if (dut.state !== BRAKE) begin miscompares++; $display("FAIL rev_brake got %0d want BRAKE", dut.state); end
        for (blen = 0; blen < 10 && dut.state === BRAKE; blen++) begin
            if (blen >= 1 && ma !== 2'b00) bad_brk = 1'b1;
            @(negedge sclk);
        end
        vectors++; if (blen != 3) begin miscompares++; $display("FAIL rev_brake_len got %0d want 3", blen); end
        vectors++; if (bad_brk) begin miscompares++; $display("FAIL rev_brake_ma got nonzero want 00"); end
        vectors++; if (dut.state !== RUN_L) begin miscompares++; $display("FAIL rev_run_l got %0d want RUN_L", dut.state); end
        vectors++; if (duty !== 4'd0 || ma !== 2'b00) begin miscompares++; $display("FAIL rev_restart got duty %0d ma %b want 0 00", duty, ma); end
        seen_l = 1'b0;
        repeat (40) begin
            @(negedge sclk);
            if (ma === 2'b11) bad_ma = 1'b1;
            if (ma === 2'b01) seen_l = 1'b1;
        end
        vectors++; if (!seen_l) begin miscompares++; $display("FAIL rev_left_drive got none want MA=01"); end
        vectors++; if (bad_ma) begin miscompares++; $display("FAIL rev_ma_11 got 11 want never"); end
    endtask

    task automatic test_key_stop();
        press_key();
        wait_for(IDLE, 20);
        vectors++; if (dut.state !== IDLE || busy !== 1'b0) begin miscompares++; $display("FAIL key_stop got %0d busy %b want IDLE 0", dut.state, busy); end
    endtask

    task automatic test_single_trip();
        int blen;
        mode = 1'b0;
        key = 1'b0;
        wait_for(RUN_L, 20);
        key = 1'b1;
        vectors++; if (dut.state !== RUN_L) begin miscompares++; $display("FAIL trip_start got %0d want RUN_L", dut.state); end
        jockey_r = 1'b0;
        repeat (10) @(negedge sclk);
        jockey_l = 1'b1;
        wait_for(BRAKE, 30);
        for (blen = 0; blen < 10 && dut.state === BRAKE; blen++) @(negedge sclk);
        vectors++; if (blen != 3) begin miscompares++; $display("FAIL trip_brake_len got %0d want 3", blen); end
        vectors++; if (dut.state !== IDLE || busy !== 1'b0) begin miscompares++; $display("FAIL trip_idle got %0d busy %b want IDLE 0", dut.state, busy); end
        jockey_l = 1'b0;
        repeat (10) @(negedge sclk);
    endtask

    task automatic test_catcher();
        bit seen_brake;
        key = 1'b0;
        wait_for(RUN_R, 20);
        key = 1'b1;
        repeat (10) @(negedge sclk);
        catcher = 1'b1;
        repeat (2) @(negedge sclk);
        catcher = 1'b0;
        repeat (20) @(negedge sclk);
        vectors++; if (dut.state !== RUN_R) begin miscompares++; $display("FAIL catch_glitch got %0d want RUN_R", dut.state); end
        catcher = 1'b1;
        seen_brake = 1'b0;
        repeat (10) begin @(negedge sclk); if (dut.state === BRAKE) seen_brake = 1'b1; end
        catcher = 1'b0;
        for (int i = 0; i < 30 && dut.state !== IDLE; i++) begin
            @(negedge sclk);
            if (dut.state === BRAKE) seen_brake = 1'b1;
        end
        vectors++; if (!seen_brake) begin miscompares++; $display("FAIL catch_brake got no BRAKE want BRAKE"); end
        vectors++; if (dut.state !== IDLE || busy !== 1'b0) begin miscompares++; $display("FAIL catch_idle got %0d busy %b want IDLE 0", dut.state, busy); end
    endtask

    task automatic test_timeout();
        int run_cyc;
        key = 1'b0;
        run_cyc = 0;
        for (int i = 0; i < 1200 && dut.state !== FAULT; i++) begin
            @(negedge sclk);
            if (i == 10) key = 1'b1;
            if (dut.state === RUN_R) run_cyc++;
        end
        key = 1'b1;
        vectors++; if (dut.state !== FAULT || fault !== 1'b1) begin miscompares++; $display("FAIL tmo_fault got %0d fault %b want FAULT 1", dut.state, fault); end
        vectors++; if (run_cyc != 1000) begin miscompares++; $display("FAIL tmo_len got %0d want 1000", run_cyc); end
        @(negedge sclk);
        vectors++; if (ma !== 2'b00 || busy !== 1'b0 || duty !== 4'd0) begin miscompares++; $display("FAIL tmo_outputs got ma %b busy %b duty %0d want 00 0 0", ma, busy, duty); end
        press_key();
        wait_for(IDLE, 10);
        vectors++; if (dut.state !== IDLE || fault !== 1'b0) begin miscompares++; $display("FAIL tmo_clear got %0d fault %b want IDLE 0", dut.state, fault); end
    endtask

    task automatic test_both_limits();
        key = 1'b0;
        wait_for(RUN_R, 20);
        key = 1'b1;
        repeat (12) @(negedge sclk);
        jockey_r = 1'b1;
        jockey_l = 1'b1;
        wait_for(FAULT, 20);
        vectors++; if (dut.state !== FAULT || fault !== 1'b1) begin miscompares++; $display("FAIL both_lim got %0d fault %b want FAULT 1", dut.state, fault); end
        press_key();
        vectors++; if (dut.state !== FAULT) begin miscompares++; $display("FAIL both_lim_hold got %0d want FAULT", dut.state); end
        jockey_r = 1'b0;
        jockey_l = 1'b0;
        repeat (10) @(negedge sclk);
        press_key();
        wait_for(IDLE, 10);
        vectors++; if (dut.state !== IDLE) begin miscompares++; $display("FAIL both_lim_clear got %0d want IDLE", dut.state); end
    endtask

    task automatic test_async_reset();
        key = 1'b0;
        wait_for(RUN_R, 20);
        key = 1'b1;
        for (int i = 0; i < 60 && ma !== 2'b10; i++) @(negedge sclk);
        vectors++; if (ma !== 2'b10) begin miscompares++; $display("FAIL arst_pre got %b want 10", ma); end
        s_rst = 1'b1;
        #1;
        vectors++; if (ma !== 2'b00) begin miscompares++; $display("FAIL arst_ma got %b want 00", ma); end
        vectors++; if (dut.state !== IDLE || busy !== 1'b0) begin miscompares++; $display("FAIL arst_state got %0d busy %b want IDLE 0", dut.state, busy); end
        @(negedge sclk);
        s_rst = 1'b0;
        repeat (10) @(negedge sclk);
    endtask

    initial begin
        s_rst = 1'b1; key = 1'b1; catcher = 1'b0;
        jockey_r = 1'b0; jockey_l = 1'b0; mode = 1'b0;
        repeat (3) @(negedge sclk);
        s_rst = 1'b0;
        @(negedge sclk);
        test_reset();
        test_ramp();
        test_reverse();
        test_key_stop();
        test_single_trip();
        test_catcher();
        test_timeout();
        test_both_limits();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shuttle_ctrl.md
# shuttle_ctrl

Parametrised single-axis shuttle controller: debounces the start/stop key, catcher sensor and left/right limit switches, then sequences an H-bridge drive through ramped PWM, dead-time braking and fault handling. It is the next-generation replacement for the key + state + pwm chain and drives the motor bridge pins `MA` directly. New behaviour:
- single-trip and continuous-shuttle modes
- soft-start duty ramp
- dead-time brake between direction changes
- run timeout and fault latch

## Interface
Parameters:
- `PWM_W`, 8: PWM counter and duty width.
- `DUTY_MAX`, 200: ramp ceiling; must be at most 2^PWM_W−1.
- `RAMP_STEP`, 4: duty increment per PWM period.
- `DEBOUNCE_CYC`, 1_000_000: stable cycles required to accept a new input level.
- `DEAD_CYC`, 50_000: brake (both bridge legs off) duration.
- `TIMEOUT_CYC`, 500_000_000: maximum cycles in one run leg.

Ports:
- `sclk` in 1: system clock; the only clock.
- `s_rst` in 1: reset, asynchronous, active-high.
- `key` in 1: raw start/stop button, active-low.
- `catcher` in 1: raw catch sensor, active-high.
- `jockey_r` in 1: raw right limit, active-high (1 = at limit).
- `jockey_l` in 1: raw left limit, active-high.
- `mode` in 1: 0 = single trip, 1 = continuous shuttle. Sampled when leaving IDLE.
- `MA` out 2: bridge drive. `MA[1]` is the right-going PWM, `MA[0]` is the left-going PWM. Never 2'b11.
- `busy` out 1: high in RUN_R, RUN_L and BRAKE.
- `fault` out 1: high in FAULT.
- `duty` out PWM_W: current duty value, for debug.

## Operation
- Each raw input passes a 2-FF synchroniser, then a debouncer. The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYC consecutive cycles.
- A key press is a 1-cycle pulse on the debounced 1→0 edge.
- A catch is a 1-cycle pulse on the debounced catcher 0→1 edge.
- Limit switches are used as debounced levels `lim_r` and `lim_l`.

States: IDLE, RUN_R, RUN_L, BRAKE, FAULT. Transition priority, highest first:
1. `lim_r && lim_l` while not in IDLE → FAULT.
2. Key press.
3. Catch.
4. Limit reached.
5. Timeout.

Transitions:
- IDLE, key press:
  - both limits high → FAULT.
  - `lim_r` high → RUN_L.
  - otherwise → RUN_R.
  - Latch `mode` into `mode_q`.
- RUN_x, key press → BRAKE, next = IDLE.
- RUN_x, catch → BRAKE, next = IDLE.
- RUN_R with `lim_r`, or RUN_L with `lim_l`:
  - `mode_q` = 0 → BRAKE, next = IDLE.
  - `mode_q` = 1 → BRAKE, next = opposite run.
- RUN_x, leg counter reaches TIMEOUT_CYC−1 → FAULT.
- BRAKE: hold for DEAD_CYC cycles, then go to next. A key press during BRAKE forces next = IDLE.
- FAULT: key press with both limits low → IDLE. Otherwise stay in FAULT.

PWM:
- `pwm_cnt` is free-running and wraps from 2^PWM_W−1 to 0.
- Active leg is high when `pwm_cnt < duty`.
- `duty` is 0 on entry to any RUN state.
- At each wrap while in RUN: `duty ← min(duty + RAMP_STEP, DUTY_MAX)`. Compute in PWM_W+1 bits, then saturate.
- `duty` is 0 in IDLE, BRAKE and FAULT.
- The leg counter clears on each RUN entry. The brake counter clears on BRAKE entry.

## Timing
- Reset values:
  - state = IDLE, `MA` = 2'b00, `busy` = 0, `fault` = 0, `duty` = 0.
  - Debounced key = 1; debounced catcher and limits = 0.
  - All counters 0.
- Assertion of `s_rst` mid-run clears `MA` immediately (asynchronously), without waiting for a clock edge.
- Raw edge to debounced change: 2 + DEBOUNCE_CYC cycles.
- Pulse to state change: 1 cycle.
- State or duty change to `MA`: 1 cycle. `MA` is registered.
- BRAKE lasts exactly DEAD_CYC cycles with `MA` = 00. Any direction reversal therefore shows at least DEAD_CYC cycles of 00.
- Simultaneous key press and limit in RUN: key wins, next = IDLE.
- Glitches shorter than DEBOUNCE_CYC cycles produce no pulse.

## Structure
- Package `shuttle_pkg`: state enum (IDLE, RUN_R, RUN_L, BRAKE, FAULT), the `MA` encodings (OFF = 00, R = 10, L = 01), and a `clog2`-based counter-width helper.
- Sub-module `sw_debounce` (parameter DEBOUNCE_CYC, INIT): synchroniser plus debouncer. Outputs `level`, `rise` and `fall`. Instantiated four times.
- FSM, ramp and PWM live in `shuttle_ctrl`.

## Test plan
Bench parameters: PWM_W=4, DUTY_MAX=12, RAMP_STEP=4, DEBOUNCE_CYC=4, DEAD_CYC=3, TIMEOUT_CYC=1000.
- Press `key` (low for 10 cycles) with no limits → RUN_R. `duty` steps 0, 4, 8, 12, then holds at 12. `MA[1]` is high for 12 of every 16 cycles; `MA[0]` stays 0.
- `mode`=1, raise `jockey_r` during RUN_R → exactly 3 cycles of `MA`=00, then RUN_L with duty restarting at 0. `MA` is never 11.
- `mode`=0, raise `jockey_l` during RUN_L → BRAKE for 3 cycles, then IDLE; `busy` falls.
- Pulse `catcher` for 2 cycles → no effect. Hold `catcher` for 10 cycles → BRAKE, then IDLE.
- Run with no limit for 1000 cycles → FAULT, `fault`=1, `MA`=00. Key press with both limits low → IDLE.
- Both limits high during RUN → FAULT. Assert `s_rst` mid-RUN → `MA`=00 in the same cycle and state = IDLE.
